// File: rtl/grf_scoreboard.sv
// rtl/grf_scoreboard.sv - general register file with per-register in-flight write scoreboard
//
// Two combinational read ports with writeback bypass, one synchronous write
// port, and a saturating in-flight write counter per register so decode can
// detect RAW hazards against writes still in the pipe.
// Optional macro GRF_TRACE_EN: prints each accepted write and each sb_err set.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   ra1/ra2 -> rd1/rd2    read address / read data (combinational, bypassed)
//   rd1_busy/rd2_busy     addressed register still has an outstanding write
//   iss_valid/iss_wa      decode issues an instruction that will write iss_wa
//   iss_ready             issue accepted this cycle (counter not saturated)
//   we/wa/wd              writeback enable / address / data
//   wpc                   PC of the writing instruction (trace only)
//   sb_err                sticky: writeback to a register with no write in flight

module grf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rd1_busy,
  output logic              rd2_busy,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_wa,
  output logic              iss_ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [31:0]       wpc,
  output logic              sb_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [CNT_W-1:0]  cnt  [DEPTH];

  logic              wr_live;     // writeback targets a real register
  logic              underflow;   // writeback with nothing in flight
  logic              dec1, dec2;
  logic [DEPTH-1:0]  inc_v, dec_v;

  // wpc only feeds the optional trace; keep it referenced in every build.
  logic unused_wpc;
  assign unused_wpc = ^wpc;

  assign wr_live   = we && (wa != '0);
  assign underflow = wr_live && (cnt[wa] == '0);

  // Read ports: register 0 is hard-wired to zero, a same-cycle writeback
  // to the addressed register is forwarded ahead of the array.
  assign rd1 = (ra1 == '0) ? '0 : ((we && wa == ra1) ? wd : regs[ra1]);
  assign rd2 = (ra2 == '0) ? '0 : ((we && wa == ra2) ? wd : regs[ra2]);

  // A final writeback landing this cycle already retires the hazard.
  assign dec1 = we && (wa == ra1) && (cnt[ra1] != '0);
  assign dec2 = we && (wa == ra2) && (cnt[ra2] != '0);
  assign rd1_busy = (ra1 != '0) && ((cnt[ra1] - CNT_W'(dec1)) != '0);
  assign rd2_busy = (ra2 != '0) && ((cnt[ra2] - CNT_W'(dec2)) != '0);

  // A saturated counter stalls issue unless a writeback frees a slot now.
  assign iss_ready = !((iss_wa != '0) && (cnt[iss_wa] == CNT_MAX) && !(we && wa == iss_wa));

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 1; i < DEPTH; i++) begin
      inc_v[i] = iss_valid && iss_ready && (iss_wa == ADDR_W'(i));
      dec_v[i] = we && (wa == ADDR_W'(i)) && (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      if (wr_live) begin
        regs[wa] <= wd;
      end
      // Counter 0 is never touched, so register 0 stays permanently idle.
      for (int i = 1; i < DEPTH; i++) begin
        case ({inc_v[i], dec_v[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
          2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
      if (underflow) begin
        sb_err <= 1'b1;
      end
    end
  end

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      if (wr_live) begin
        $display("%d@%h: $%d <= %h", $time, wpc, wa, wd);
      end
      if (underflow && !sb_err) begin
        $display("SB underflow @%h", wpc);
      end
    end
  end
`else
`endif

endmodule
